sort4_feeder: RTL and testbench



---
 rtl/sort4_feeder.sv | 74 +++++++
 tb/tb_sort4_feeder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sort4_feeder.sv
// sort4_feeder: packs a valid/ready stream of signed samples into indexed 4-entry groups for sort4.
// Define SORT4_FEEDER_PAD_EN to pad and emit partial groups on flush instead of discarding them.
module sort4_feeder #(
    parameter int VAL_W = 6,
    parameter int IDX_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VAL_W-1:0]       in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VAL_W+IDX_W-1:0] grp_1,
    output logic [VAL_W+IDX_W-1:0] grp_2,
    output logic [VAL_W+IDX_W-1:0] grp_3,
    output logic [VAL_W+IDX_W-1:0] grp_4,
    output logic [2:0]             grp_count
);
`ifdef SORT4_FEEDER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam logic [VAL_W+IDX_W-1:0] PAD = {1'b1, {(VAL_W+IDX_W-1){1'b0}}};
    typedef enum logic {FILL, HOLD} state_t;
    state_t state, next_state;
    logic [1:0] cnt;
    logic [2:0] cnt_n;
    logic [IDX_W-1:0] idx;
    logic [VAL_W+IDX_W-1:0] slot [4];
    logic accept, complete, close;

    assign accept = in_valid & in_ready;
    assign cnt_n = {1'b0, cnt} + {2'b0, accept};
    assign complete = cnt_n[2];
    // flush sees the count after any same-cycle accept; a completing accept wins
    assign close = flush & in_ready & ~complete & (cnt_n != 3'd0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FILL;
        else state <= next_state;

    always_comb
        next_state = state == FILL ? ((complete || (PAD_EN && close)) ? HOLD : FILL)
                                   : (out_ready ? FILL : HOLD);

    always_comb begin
        in_ready = state == FILL;
        out_valid = state == HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= IDX_W'(1);
            grp_count <= '0;
            for (int i = 0; i < 4; i++) slot[i] <= '0;
        end else if (in_ready) begin
            cnt <= close ? 2'd0 : cnt_n[1:0];
            idx <= accept ? (&idx ? IDX_W'(1) : idx + 1'b1) : idx;
            grp_count <= complete ? 3'd4 : (PAD_EN && close) ? cnt_n : grp_count;
            for (int i = 0; i < 4; i++)
                if (accept && cnt == 2'(i)) slot[i] <= {in_data, idx};
                else if (PAD_EN && close && cnt_n <= 3'(i)) slot[i] <= PAD;
        end
    end

    assign grp_1 = slot[0];
    assign grp_2 = slot[1];
    assign grp_3 = slot[2];
    assign grp_4 = slot[3];
endmodule

// File: tb/tb_sort4_feeder.sv
// tb_sort4_feeder: directed self-checking bench for sort4_feeder (honours SORT4_FEEDER_PAD_EN).
module tb_sort4_feeder;
    logic clk = 0, rst_n = 0, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
    logic [5:0] in_data = '0;
    logic [10:0] grp_1, grp_2, grp_3, grp_4;
    logic [2:0] grp_count;
    logic [43:0] grp_all;
    int n_chk = 0, n_pass = 0, k, ng, last;
    bit acc;

    sort4_feeder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .grp_1(grp_1), .grp_2(grp_2), .grp_3(grp_3), .grp_4(grp_4), .grp_count(grp_count)
    );

    assign grp_all = {grp_4, grp_3, grp_2, grp_1};
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int v, input bit f);
        in_valid = 1;
        in_data = 6'(v);
        flush = f;
        tick(1);
        in_valid = 0;
        flush = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        tick(1);
        out_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #3;
        rst_n = 1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ov"}, 32'(out_valid), 0);
        check({tag, "_ir"}, 32'(in_ready), 1);
        check({tag, "_grp"}, 32'(grp_all), 0);
        check({tag, "_cnt"}, 32'(grp_count), 0);
    endtask

    function automatic logic [10:0] ent(input int n);
        logic [5:0] v;
        logic [4:0] ix;
        v = 6'(n - 20);
        ix = 5'((n % 31) + 1);
        return {v, ix};
    endfunction

    initial begin
        #12;
        check_reset("rst");
        rst_n = 1;
        push(4, 0); push(-2, 0); push(-32, 0); push(-11, 0);
        check("g1_ov", 32'(out_valid), 1);
        check("g1_ir", 32'(in_ready), 0);
        check("g1_1", 32'(grp_1), 32'h081);
        check("g1_2", 32'(grp_2), 32'h7C2);
        check("g1_3", 32'(grp_3), 32'h403);
        check("g1_4", 32'(grp_4), 32'h6A4);
        check("g1_cnt", 32'(grp_count), 4);
        tick(10);
        check("hold_ov", 32'(out_valid), 1);
        check("hold_grp", 32'(grp_all), {11'h6A4, 11'h403, 11'h7C2, 11'h081});
        check("hold_cnt", 32'(grp_count), 4);
        drain();
        check("drain_ov", 32'(out_valid), 0);
        check("drain_ir", 32'(in_ready), 1);

        do_reset();
        k = 0; ng = 0; last = 0;
        in_valid = 1; in_data = 6'(-20); out_ready = 1;
        for (int c = 0; c < 300 && ng < 10; c++) begin
            acc = in_ready && in_valid;
            tick(1);
            if (acc) begin
                k++;
                in_data = 6'(k - 20);
                if (k == 40) in_valid = 0;
            end
            if (out_valid) begin
                for (int e = 0; e < 4; e++) check("stream", 32'(grp_all[e*11 +: 11]), 32'(ent(4*ng + e)));
                check("stream_cnt", 32'(grp_count), 4);
                if (ng > 0) check("period", c - last, 5);
                last = c;
                ng++;
            end
        end
        check("groups", ng, 10);
        out_ready = 0;
        in_valid = 0;

        do_reset();
        push(7, 0); push(3, 0);
        flush = 1; tick(1); flush = 0;
`ifdef SORT4_FEEDER_PAD_EN
        check("pad_ov", 32'(out_valid), 1);
        check("pad_grp", 32'(grp_all), {11'h400, 11'h400, 11'h062, 11'h0E1});
        check("pad_cnt", 32'(grp_count), 2);
        drain();
`else
        check("disc_ov", 32'(out_valid), 0);
        check("disc_ir", 32'(in_ready), 1);
        tick(2);
        check("disc_ov2", 32'(out_valid), 0);
`endif
        push(1, 0); push(2, 0); push(3, 0); push(4, 0);
        check("post_ov", 32'(out_valid), 1);
        check("post_1", 32'(grp_1), 32'h023);
        check("post_4", 32'(grp_4), 32'h086);
        check("post_cnt", 32'(grp_count), 4);
        drain();

        push(1, 0); push(2, 0); push(3, 0); push(4, 1);
        check("fl4_ov", 32'(out_valid), 1);
        check("fl4_cnt", 32'(grp_count), 4);
        check("fl4_3", 32'(grp_3), 32'h069);
        check("fl4_4", 32'(grp_4), 32'h08A);
        flush = 1; tick(1); flush = 0;
        check("flh_ov", 32'(out_valid), 1);
        check("flh_cnt", 32'(grp_count), 4);
        check("flh_1", 32'(grp_1), 32'h027);
        drain();
        check("flh_drain", 32'(out_valid), 0);

        push(5, 0); push(6, 0); push(7, 0); push(8, 0);
        check("rh_pre", 32'(out_valid), 1);
        #2 rst_n = 0;
        #1 check_reset("rst_hold");
        rst_n = 1;
        tick(1);
        push(9, 0); push(10, 0);
        #2 rst_n = 0;
        #1 check_reset("rst_fill");
        rst_n = 1;
        tick(1);
        push(1, 0); push(2, 0); push(3, 0); push(4, 0);
        check("rel_ov", 32'(out_valid), 1);
        check("rel_1", 32'(grp_1), 32'h021);
        check("rel_4", 32'(grp_4), 32'h084);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
